// File: rtl/ms_section_rr_slave.sv
// Round-robin section machine: SECTION_A samples the channel under the pointer,
// SECTION_B publishes sample+INC tagged with its source channel.
module ms_section_rr_slave #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       NUM_CH    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(1337),
  parameter logic [DATA_W-1:0] INC       = DATA_W'(1),
  localparam int unsigned      CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] s_in,
  input  logic [NUM_CH-1:0]        s_in_sync,
  output logic [NUM_CH-1:0]        s_in_ack,
  input  logic                     hold,
  output logic [DATA_W-1:0]        s_out,
  output logic                     s_out_valid,
  output logic [CH_W-1:0]          s_out_ch
);

  typedef enum logic [0:0] {
    SEC_A = 1'b0,
    SEC_B = 1'b1
  } section_e;

  section_e          section_r;
  logic [CH_W-1:0]   ptr_r;
  logic [CH_W-1:0]   ch_r;
  logic [DATA_W-1:0] val_r;
  logic [DATA_W-1:0] ch_data_s [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_data_s[i] = s_in[i*DATA_W +: DATA_W];
  end

  // Explicit wrap so a non-power-of-two channel count never indexes past NUM_CH-1.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] p);
    if (p == CH_W'(NUM_CH - 1)) begin
      return {CH_W{1'b0}};
    end else begin
      return p + CH_W'(1);
    end
  endfunction

  // Section FSM, round-robin pointer and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      section_r   <= SEC_A;
      ptr_r       <= {CH_W{1'b0}};
      ch_r        <= {CH_W{1'b0}};
      val_r       <= RESET_VAL;
      s_out       <= RESET_VAL;
      s_out_ch    <= {CH_W{1'b0}};
      s_out_valid <= 1'b0;
      s_in_ack    <= {NUM_CH{1'b0}};
    end else begin
      s_in_ack    <= {NUM_CH{1'b0}};
      s_out_valid <= 1'b0;
      if (!hold) begin
        case (section_r)
          SEC_A: begin
            if (s_in_sync[ptr_r]) begin
              val_r     <= ch_data_s[ptr_r];
              ch_r      <= ptr_r;
              s_in_ack  <= NUM_CH'(1) << ptr_r;
              section_r <= SEC_B;
            end else begin
              ptr_r <= next_ch(ptr_r);
            end
          end
          SEC_B: begin
            s_out       <= val_r + INC;
            s_out_ch    <= ch_r;
            s_out_valid <= 1'b1;
            ptr_r       <= next_ch(ch_r);
            section_r   <= SEC_A;
          end
          default: begin
            section_r <= SEC_A;
            ptr_r     <= {CH_W{1'b0}};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ms_section_rr_slave.sv
// Bench for ms_section_rr_slave: directed scenarios plus randomized producers
// checked against a transaction-level round-robin model.
module tb_ms_section_rr_slave;

  localparam int          DATA_W = 32;
  localparam int          NUM_CH = 4;
  localparam logic [31:0] RST_V  = 32'd1337;
  localparam logic [31:0] INC    = 32'd1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH*DATA_W-1:0] s_in;
  logic [NUM_CH-1:0]        s_in_sync;
  logic [NUM_CH-1:0]        s_in_ack;
  logic                     hold;
  logic [DATA_W-1:0]        s_out;
  logic                     s_out_valid;
  logic [1:0]               s_out_ch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ms_section_rr_slave #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .RESET_VAL(RST_V), .INC(INC)
  ) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .s_in_sync(s_in_sync), .s_in_ack(s_in_ack),
    .hold(hold), .s_out(s_out), .s_out_valid(s_out_valid), .s_out_ch(s_out_ch)
  );

  task automatic set_ch(input int c, input logic [31:0] v, input logic s);
    s_in[c*DATA_W +: DATA_W] = v;
    s_in_sync[c] = s;
  endtask

  // one rising edge, return at the following falling edge for sampling/driving
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; s_in = '0; s_in_sync = 4'b0; hold = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; s_in = '0; s_in_sync = 4'b0; hold = 1'b0;
    #2;
    checks++;
    if (s_out !== RST_V || s_out_ch !== 2'd0 || s_out_valid !== 1'b0 || s_in_ack !== 4'b0) begin
      errors++;
      $display("FAIL reset_state: out=%0d ch=%0d valid=%b ack=%b, want 1337/0/0/0000",
               s_out, s_out_ch, s_out_valid, s_in_ack);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (s_out !== RST_V || s_out_ch !== 2'd0 || s_out_valid !== 1'b0 || s_in_ack !== 4'b0) begin
        errors++;
        $display("FAIL idle_after_reset[%0d]: out=%0d ch=%0d valid=%b ack=%b, want 1337/0/0/0000",
                 i, s_out, s_out_ch, s_out_valid, s_in_ack);
      end
    end
  endtask

  task automatic test_single_channel();
    int n = 0;
    do_reset();
    set_ch(2, 32'd5, 1'b1);
    while (n < 8 && s_in_ack === 4'b0) begin
      step();
      n++;
    end
    checks++;
    if (n != 3 || s_in_ack !== 4'b0100) begin
      errors++;
      $display("FAIL single_ack: ack=%b after %0d edges, want 0100 after 3", s_in_ack, n);
    end
    set_ch(2, 32'd0, 1'b0);
    step();
    checks++;
    if (s_out !== 32'd6 || s_out_ch !== 2'd2 || s_out_valid !== 1'b1 || s_in_ack !== 4'b0) begin
      errors++;
      $display("FAIL single_result: out=%0d ch=%0d valid=%b ack=%b, want 6/2/1/0000",
               s_out, s_out_ch, s_out_valid, s_in_ack);
    end
    step();
    checks++;
    if (s_out !== 32'd6 || s_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_hold_out: out=%0d valid=%b, want 6/0", s_out, s_out_valid);
    end
  endtask

  task automatic test_all_channels();
    logic [31:0] vals [4] = '{32'd10, 32'd20, 32'd30, 32'd40};
    logic [3:0]  one = 4'b0001;
    int t;
    do_reset();
    for (int c = 0; c < NUM_CH; c++) set_ch(c, vals[c], 1'b1);
    for (int k = 0; k < 10; k++) begin
      step();
      t = (k / 2) % NUM_CH;
      checks++;
      if (k % 2 == 0) begin
        if (s_in_ack !== (one << t) || s_out_valid !== 1'b0) begin
          errors++;
          $display("FAIL all_ch_ack[%0d]: ack=%b valid=%b, want %b/0", k, s_in_ack, s_out_valid, one << t);
        end
      end else begin
        if (s_out !== vals[t] + INC || s_out_ch !== 2'(t) || s_out_valid !== 1'b1 || s_in_ack !== 4'b0) begin
          errors++;
          $display("FAIL all_ch_result[%0d]: out=%0d ch=%0d valid=%b ack=%b, want %0d/%0d/1/0000",
                   k, s_out, s_out_ch, s_out_valid, s_in_ack, vals[t] + INC, t);
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    set_ch(0, 32'hFFFF_FFFF, 1'b1);
    step();
    checks++;
    if (s_in_ack !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_ack: ack=%b, want 0001", s_in_ack);
    end
    set_ch(0, 32'd0, 1'b0);
    step();
    checks++;
    if (s_out !== 32'd0 || s_out_ch !== 2'd0 || s_out_valid !== 1'b1 || s_in_ack !== 4'b0) begin
      errors++;
      $display("FAIL wrap_result: out=%h ch=%0d valid=%b ack=%b, want 0/0/1/0000",
               s_out, s_out_ch, s_out_valid, s_in_ack);
    end
  endtask

  task automatic test_hold_in_b();
    do_reset();
    set_ch(0, 32'd7, 1'b1);
    step();
    checks++;
    if (s_in_ack !== 4'b0001) begin
      errors++;
      $display("FAIL hold_pre_ack: ack=%b, want 0001", s_in_ack);
    end
    set_ch(0, 32'd0, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (s_out_valid !== 1'b0 || s_in_ack !== 4'b0 || s_out !== RST_V || s_out_ch !== 2'd0) begin
        errors++;
        $display("FAIL hold_frozen[%0d]: out=%0d ch=%0d valid=%b ack=%b, want 1337/0/0/0000",
                 i, s_out, s_out_ch, s_out_valid, s_in_ack);
      end
    end
    hold = 1'b0;
    step();
    checks++;
    if (s_out !== 32'd8 || s_out_valid !== 1'b1 || s_out_ch !== 2'd0) begin
      errors++;
      $display("FAIL hold_release: out=%0d ch=%0d valid=%b, want 8/0/1", s_out, s_out_ch, s_out_valid);
    end
  endtask

  task automatic test_reset_in_b();
    int n = 0;
    do_reset();
    set_ch(1, 32'd9, 1'b1);
    while (n < 8 && s_in_ack === 4'b0) begin
      step();
      n++;
    end
    checks++;
    if (n != 2 || s_in_ack !== 4'b0010) begin
      errors++;
      $display("FAIL rstb_ack: ack=%b after %0d edges, want 0010 after 2", s_in_ack, n);
    end
    set_ch(1, 32'd0, 1'b0);
    rst = 1'b0;
    #2;
    checks++;
    if (s_out !== RST_V || s_out_ch !== 2'd0 || s_out_valid !== 1'b0 || s_in_ack !== 4'b0) begin
      errors++;
      $display("FAIL rstb_state: out=%0d ch=%0d valid=%b ack=%b, want 1337/0/0/0000",
               s_out, s_out_ch, s_out_valid, s_in_ack);
    end
    @(negedge clk);
    checks++;
    if (s_out_valid !== 1'b0 || s_out !== RST_V) begin
      errors++;
      $display("FAIL rstb_no_write: out=%0d valid=%b, want 1337/0", s_out, s_out_valid);
    end
    rst = 1'b1;
    set_ch(0, 32'd3, 1'b1);
    set_ch(1, 32'd4, 1'b1);
    step();
    checks++;
    if (s_in_ack !== 4'b0001) begin
      errors++;
      $display("FAIL rstb_ptr0: ack=%b, want 0001", s_in_ack);
    end
    set_ch(0, 32'd0, 1'b0);
    set_ch(1, 32'd0, 1'b0);
    step();
    checks++;
    if (s_out !== 32'd4 || s_out_ch !== 2'd0 || s_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstb_result: out=%0d ch=%0d valid=%b, want 4/0/1", s_out, s_out_ch, s_out_valid);
    end
  endtask

  // Transaction model: one accepted sample becomes one result on the next unheld
  // edge; priority then moves to the channel after the one just served.
  task automatic test_random();
    int          prio      = 0;
    bit          pending   = 1'b0;
    logic [31:0] pend_res  = 32'd0;
    int          pend_ch   = 0;
    logic [31:0] exp_out   = RST_V;
    int          exp_ch    = 0;
    logic [3:0]  exp_ack   = 4'b0;
    logic        exp_valid = 1'b0;
    logic [3:0]  one       = 4'b0001;
    logic [31:0] v;
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (s_in_sync[c] && (exp_ack[c] || $urandom_range(15, 0) == 0)) begin
          set_ch(c, 32'd0, 1'b0);
        end else if (!s_in_sync[c] && $urandom_range(2, 0) == 0) begin
          v = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFF : $urandom;
          set_ch(c, v, 1'b1);
        end
      end
      hold = ($urandom_range(7, 0) == 0);
      exp_ack = 4'b0;
      exp_valid = 1'b0;
      if (!hold) begin
        if (pending) begin
          exp_out = pend_res;
          exp_ch = pend_ch;
          exp_valid = 1'b1;
          pending = 1'b0;
          prio = (pend_ch + 1) % NUM_CH;
        end else if (s_in_sync[prio]) begin
          pend_res = s_in[prio*DATA_W +: DATA_W] + INC;
          pend_ch = prio;
          pending = 1'b1;
          exp_ack = one << prio;
        end else begin
          prio = (prio + 1) % NUM_CH;
        end
      end
      step();
      checks++;
      if (s_in_ack !== exp_ack) begin
        errors++;
        $display("FAIL rand_ack[%0d]: got %b want %b", cyc, s_in_ack, exp_ack);
      end
      checks++;
      if (s_out_valid !== exp_valid) begin
        errors++;
        $display("FAIL rand_valid[%0d]: got %b want %b", cyc, s_out_valid, exp_valid);
      end
      checks++;
      if (s_out !== exp_out) begin
        errors++;
        $display("FAIL rand_out[%0d]: got %h want %h", cyc, s_out, exp_out);
      end
      checks++;
      if (s_out_ch !== 2'(exp_ch)) begin
        errors++;
        $display("FAIL rand_ch[%0d]: got %0d want %0d", cyc, s_out_ch, exp_ch);
      end
    end
    hold = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    s_in = '0;
    s_in_sync = 4'b0;
    hold = 1'b0;
    test_reset();
    test_single_channel();
    test_all_channels();
    test_wrap();
    test_hold_in_b();
    test_reset_in_b();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
